spi_slv16: RTL and testbench
============================

Name: spi_slv16

Overview:
- 16-bit SPI slave; the responder end of the team's 16-bit SPI master (SCLK = clk/32, mode 0, MSB first, SS_n active low).
- Receives a 16-bit command on MOSI while shifting a 16-bit response out on MISO.
- Used to emulate peripherals (inertial sensor, A2D) in system benches, and as the synthesizable responder in the loopback test fabric.
- All SPI inputs are asynchronous to clk and are synchronized internally.

Parameters:
- SYNC_STAGES, 2, flop stages on SS_n/SCLK/MOSI before edge detection (legal values: 2 or 3).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- SS_n  input  1  slave select from master, active low, asynchronous.
- SCLK  input  1  serial clock from master, asynchronous.
- MOSI  input  1  serial data from master.
- MISO  output  1  serial data to master; high-Z whenever raw SS_n is high.
- tx_data  input  16  response word; captured on detected SS_n fall.
- rx_data  output  16  last complete command received; held until the next good frame.
- rdy  output  1  one-clk pulse when rx_data updates.
- busy  output  1  high while in XFER or FINISH.
- frm_err  output  1  one-clk pulse on an aborted or overlong frame.

Behaviour:
- Reset: all outputs go to 0 (rx_data=16'h0000, rdy=0, busy=0, frm_err=0); MISO is high-Z because SS_n is high. Shift reg=0, bit_cnt=0, state=IDLE.
- Reset values of synchronizer chains are 0, so no spurious SS_n fall is seen after reset.
- A master already mid-frame at reset release is ignored until SS_n goes high and falls again.
- Sync: each input passes through SYNC_STAGES flops, then one more flop for the edge compare.
  - ss_fall, sclk_rise and sclk_fall are single-clk pulses.
  - Detection latency is SYNC_STAGES+1 clks after the pin edge.
- Datapath:
  - shft[15:0]; MISO = shft[15] when SS_n=0.
  - mosi_smpl is a 1-bit register.
  - bit_cnt[4:0] counts sampled bits, 0..16.
- States:
  - IDLE, busy=0:
    - on ss_fall: shft<=tx_data, bit_cnt<=0, go to XFER.
    - All other edges ignored, including SS_n rise.
  - XFER, busy=1:
    - sclk_rise with bit_cnt<16: mosi_smpl<=sync MOSI; bit_cnt++.
    - sclk_rise with bit_cnt==16: overlong frame; pulse frm_err, go to IDLE on SS_n rise with no rdy.
    - sclk_fall with bit_cnt==0: ignored (master's leading fall).
    - sclk_fall with bit_cnt>=1: shft<={shft[14:0],mosi_smpl}.
    - SS_n rise with bit_cnt==16: go to FINISH.
    - SS_n rise with bit_cnt!=16: pulse frm_err, rx_data unchanged, go to IDLE.
  - FINISH, busy=1, one clk:
    - rx_data<={shft[14:0],mosi_smpl}, i.e. the final shift of the 16th bit; rdy=1.
    - Then go to IDLE.
- Simultaneous events:
  - SS_n rise and an SCLK edge in the same clk: SS_n rise wins; the SCLK edge is dropped.
  - sclk_rise and sclk_fall in the same clk cannot occur (they share one chain).
- Timing margin: MISO updates SYNC_STAGES+1 clks after an SCLK fall. This is at most 4 clks, well inside the 16-clk half period, so MISO is stable at the master's next rise.
- Back-to-back frames: a new ss_fall seen in IDLE the clk after FINISH is accepted. tx_data is sampled on that ss_fall.
- rdy and frm_err are never high in the same cycle.

Test Plan:
- Drive the team's SPI master: cmd=16'hA55A, tx_data=16'h3CC3 → slave rdy pulses once, rx_data=16'hA55A; master rd_data=16'h3CC3; frm_err stays 0.
- Two back-to-back frames, cmd=16'h0001 then 16'h8000, tx_data changed between frames to 16'hFFFF then 16'h0000 → rx_data 16'h0001 then 16'h8000; master reads 16'hFFFF then 16'h0000; exactly 2 rdy pulses.
- Bit-banged frame aborted after 9 rising SCLK edges (SS_n raised) → frm_err pulses once, rdy=0, rx_data keeps its prior value 16'hA55A, busy drops within SYNC_STAGES+2 clks.
- Bit-banged frame with 17 rising edges → frm_err pulses on the 17th edge; no rdy at SS_n rise.
- Assert rst for 3 clks mid-frame after 8 bits, keep SS_n low and continue clocking, then start a full new frame with 16'h1234 → no rdy or frm_err from the broken frame; new frame gives rx_data=16'h1234.
- SS_n high throughout with SCLK and MOSI toggling → MISO is Z, busy=0, no pulses; with SS_n low before any SCLK edge, MISO=tx_data[15].

Source files
------------

// File: rtl/spi_slv16_if.sv
// Host-side handshake of the 16-bit SPI slave: response word in, received
// command plus status pulses out.
interface spi_slv16_if;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rdy;
  logic        busy;
  logic        frm_err;

  modport slave (
    input  tx_data,
    output rx_data, rdy, busy, frm_err
  );

  modport master (
    output tx_data,
    input  rx_data, rdy, busy, frm_err
  );
endinterface

// File: rtl/spi_slv16.sv
// 16-bit mode-0 SPI slave: oversamples SS_n/SCLK/MOSI on clk, shifts a
// command in on MOSI while shifting tx_data out on MISO.
module spi_slv16 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output wire  MISO,
  spi_slv16_if.slave host
);

  typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_q, sclk_q;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

  state_t      state;
  logic [15:0] shft;
  logic [4:0]  bit_cnt;
  logic        mosi_smpl;
  logic        ovl;
  logic [15:0] rx_data;
  logic        rdy, busy, frm_err;

  // NOTE: chains reset to 0 so a master already holding SS_n low at reset
  // release never produces a falling edge; the frame is ignored until SS_n
  // goes high and falls again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_q      <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_q      <= ss_s;
      sclk_q    <= sclk_s;
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_q & ~ss_s;
  assign ss_rise   = ~ss_q & ss_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;

  // NOTE: all state below uses non-blocking assignments so every branch reads
  // the pre-edge values, exactly like the flops it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shft      <= 16'h0000;
      bit_cnt   <= 5'd0;
      mosi_smpl <= 1'b0;
      ovl       <= 1'b0;
      rx_data   <= 16'h0000;
      rdy       <= 1'b0;
      busy      <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            shft    <= host.tx_data;
            bit_cnt <= 5'd0;
            ovl     <= 1'b0;
            busy    <= 1'b1;
            state   <= XFER;
          end
        end
        XFER: begin
          // SS_n rise has priority; an SCLK edge in the same clk is dropped.
          if (ss_rise) begin
            if (ovl) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (bit_cnt == 5'd16) begin
              state <= FINISH;
            end else begin
              frm_err <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end else if (sclk_rise) begin
            if (bit_cnt == 5'd16) begin
              frm_err <= ~ovl;
              ovl     <= 1'b1;
            end else begin
              mosi_smpl <= mosi_s;
              bit_cnt   <= bit_cnt + 5'd1;
            end
          end else if (sclk_fall && bit_cnt != 5'd0) begin
            shft <= {shft[14:0], mosi_smpl};
          end
        end
        FINISH: begin
          rx_data <= {shft[14:0], mosi_smpl};
          rdy     <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign MISO         = SS_n ? 1'bz : shft[15];
  assign host.rx_data = rx_data;
  assign host.rdy     = rdy;
  assign host.busy    = busy;
  assign host.frm_err = frm_err;

endmodule

// File: tb/tb_spi_slv16.sv
// Bench for spi_slv16: a behavioural mode-0 master (SCLK = clk/32) drives
// directed and randomized frames; expectations come from the frame rules.
module tb_spi_slv16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 16;

  logic clk = 1'b0;
  logic rst;
  logic SS_n, SCLK, MOSI;
  wire  MISO;

  spi_slv16_if host_if ();

  spi_slv16 #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk  (clk),
    .rst  (rst),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO),
    .host (host_if.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int err_at_last_rise;
  int err_before_ss;
  logic [15:0] exp_rx = 16'h0000;

  always @(negedge clk) begin
    if (!rst) begin
      if (host_if.rdy) rdy_cnt++;
      if (host_if.frm_err) err_cnt++;
      if (host_if.rdy && host_if.frm_err) both_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ss_low();
    @(posedge clk);
    #1 SS_n = 1'b0;
    tick(HALF);
  endtask

  task automatic spi_bit(input logic b, output logic miso_bit);
    SCLK = 1'b0;
    MOSI = b;
    tick(HALF);
    SCLK = 1'b1;
    miso_bit = MISO;
    err_at_last_rise = err_cnt;
    tick(HALF);
  endtask

  task automatic ss_high();
    err_before_ss = err_cnt;
    SS_n = 1'b1;
    MOSI = 1'b0;
  endtask

  task automatic do_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] rd);
    logic mb;
    logic b;
    rd = 16'h0000;
    ss_low();
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? cmd[15-i] : 1'($urandom);
      spi_bit(b, mb);
      rd = {rd[14:0], mb};
    end
    ss_high();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    n_vec++; if (host_if.rx_data !== 16'h0000) begin n_err++; $display("FAIL reset_rx_data got=%h exp=0000", host_if.rx_data); end
    n_vec++; if (host_if.rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b exp=0", host_if.rdy); end
    n_vec++; if (host_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", host_if.busy); end
    n_vec++; if (host_if.frm_err !== 1'b0) begin n_err++; $display("FAIL reset_frm_err got=%b exp=0", host_if.frm_err); end
    rst = 1'b0;
    tick(10);
  endtask

  task automatic test_basic();
    int r0, e0;
    logic [15:0] rd;
    r0 = rdy_cnt; e0 = err_cnt;
    host_if.tx_data = 16'h3CC3;
    do_frame(16'hA55A, 16, rd);
    tick(8);
    n_vec++; if (host_if.rx_data !== 16'hA55A) begin n_err++; $display("FAIL basic_rx got=%h exp=a55a", host_if.rx_data); end
    n_vec++; if (rd !== 16'h3CC3) begin n_err++; $display("FAIL basic_miso got=%h exp=3cc3", rd); end
    n_vec++; if (rdy_cnt - r0 !== 1) begin n_err++; $display("FAIL basic_rdy_pulses got=%0d exp=1", rdy_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL basic_frm_err got=%0d exp=0", err_cnt - e0); end
    n_vec++; if (host_if.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_idle got=%b exp=0", host_if.busy); end
    exp_rx = 16'hA55A;
  endtask

  task automatic test_abort();
    int r0, e0;
    logic [15:0] rd;
    r0 = rdy_cnt; e0 = err_cnt;
    host_if.tx_data = 16'h5A5A;
    do_frame(16'h0F0F, 9, rd);
    @(negedge clk);
    n_vec++; if (host_if.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before got=%b exp=1", host_if.busy); end
    tick(SYNC_STAGES + 1);
    n_vec++; if (host_if.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_drop got=%b exp=0", host_if.busy); end
    tick(8);
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL abort_frm_err got=%0d exp=1", err_cnt - e0); end
    n_vec++; if (rdy_cnt - r0 !== 0) begin n_err++; $display("FAIL abort_rdy got=%0d exp=0", rdy_cnt - r0); end
    n_vec++; if (host_if.rx_data !== exp_rx) begin n_err++; $display("FAIL abort_rx_held got=%h exp=%h", host_if.rx_data, exp_rx); end
  endtask

  task automatic test_back_to_back();
    int r0, e0;
    logic [15:0] rd;
    r0 = rdy_cnt; e0 = err_cnt;
    host_if.tx_data = 16'hFFFF;
    do_frame(16'h0001, 16, rd);
    tick(SYNC_STAGES + 2);
    n_vec++; if (host_if.rx_data !== 16'h0001) begin n_err++; $display("FAIL b2b_rx1 got=%h exp=0001", host_if.rx_data); end
    n_vec++; if (rd !== 16'hFFFF) begin n_err++; $display("FAIL b2b_miso1 got=%h exp=ffff", rd); end
    host_if.tx_data = 16'h0000;
    do_frame(16'h8000, 16, rd);
    tick(8);
    n_vec++; if (host_if.rx_data !== 16'h8000) begin n_err++; $display("FAIL b2b_rx2 got=%h exp=8000", host_if.rx_data); end
    n_vec++; if (rd !== 16'h0000) begin n_err++; $display("FAIL b2b_miso2 got=%h exp=0000", rd); end
    n_vec++; if (rdy_cnt - r0 !== 2) begin n_err++; $display("FAIL b2b_rdy_pulses got=%0d exp=2", rdy_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL b2b_frm_err got=%0d exp=0", err_cnt - e0); end
    exp_rx = 16'h8000;
  endtask

  task automatic test_overlong();
    int r0, e0;
    logic [15:0] rd;
    r0 = rdy_cnt; e0 = err_cnt;
    host_if.tx_data = 16'h1357;
    do_frame(16'hBEEF, 17, rd);
    n_vec++; if (err_before_ss - err_at_last_rise !== 1) begin n_err++; $display("FAIL ovl_err_on_17th got=%0d exp=1", err_before_ss - err_at_last_rise); end
    tick(8);
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL ovl_err_total got=%0d exp=1", err_cnt - e0); end
    n_vec++; if (rdy_cnt - r0 !== 0) begin n_err++; $display("FAIL ovl_rdy got=%0d exp=0", rdy_cnt - r0); end
    n_vec++; if (host_if.rx_data !== exp_rx) begin n_err++; $display("FAIL ovl_rx_held got=%h exp=%h", host_if.rx_data, exp_rx); end
    n_vec++; if (host_if.busy !== 1'b0) begin n_err++; $display("FAIL ovl_busy got=%b exp=0", host_if.busy); end
  endtask

  task automatic test_random();
    int r0, e0, nbits;
    logic [15:0] cmd, tx, rd;
    for (int i = 0; i < 20; i++) begin
      cmd = 16'($urandom);
      tx  = 16'($urandom);
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      r0 = rdy_cnt; e0 = err_cnt;
      host_if.tx_data = tx;
      do_frame(cmd, nbits, rd);
      tick(8 + $urandom_range(0, 6));
      if (nbits == 16) exp_rx = cmd;
      n_vec++; if (host_if.rx_data !== exp_rx) begin n_err++; $display("FAIL rand_rx[%0d] bits=%0d got=%h exp=%h", i, nbits, host_if.rx_data, exp_rx); end
      n_vec++; if (rdy_cnt - r0 !== ((nbits == 16) ? 1 : 0)) begin n_err++; $display("FAIL rand_rdy[%0d] bits=%0d got=%0d", i, nbits, rdy_cnt - r0); end
      n_vec++; if (err_cnt - e0 !== ((nbits == 16) ? 0 : 1)) begin n_err++; $display("FAIL rand_frm_err[%0d] bits=%0d got=%0d", i, nbits, err_cnt - e0); end
      if (nbits == 16) begin
        n_vec++; if (rd !== tx) begin n_err++; $display("FAIL rand_miso[%0d] got=%h exp=%h", i, rd, tx); end
      end
    end
  endtask

  task automatic test_rst_midframe();
    int r0, e0;
    logic mb;
    logic [15:0] cmd, rd;
    cmd = 16'hC3A5;
    host_if.tx_data = 16'h7777;
    ss_low();
    for (int i = 0; i < 8; i++) spi_bit(cmd[15-i], mb);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    r0 = rdy_cnt; e0 = err_cnt;
    for (int i = 8; i < 16; i++) spi_bit(cmd[15-i], mb);
    ss_high();
    tick(10);
    n_vec++; if (rdy_cnt - r0 !== 0) begin n_err++; $display("FAIL rstmid_rdy got=%0d exp=0", rdy_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL rstmid_frm_err got=%0d exp=0", err_cnt - e0); end
    n_vec++; if (host_if.rx_data !== 16'h0000) begin n_err++; $display("FAIL rstmid_rx got=%h exp=0000", host_if.rx_data); end
    n_vec++; if (host_if.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", host_if.busy); end
    r0 = rdy_cnt;
    host_if.tx_data = 16'h9ABC;
    do_frame(16'h1234, 16, rd);
    tick(8);
    n_vec++; if (host_if.rx_data !== 16'h1234) begin n_err++; $display("FAIL rstmid_new_rx got=%h exp=1234", host_if.rx_data); end
    n_vec++; if (rd !== 16'h9ABC) begin n_err++; $display("FAIL rstmid_new_miso got=%h exp=9abc", rd); end
    n_vec++; if (rdy_cnt - r0 !== 1) begin n_err++; $display("FAIL rstmid_new_rdy got=%0d exp=1", rdy_cnt - r0); end
    exp_rx = 16'h1234;
  endtask

  task automatic test_ss_high();
    int r0, e0;
    logic busy_seen;
    logic [15:0] tx;
    r0 = rdy_cnt; e0 = err_cnt; busy_seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      SCLK = 1'($urandom);
      MOSI = 1'($urandom);
      tick(1);
      if (host_if.busy !== 1'b0) busy_seen = 1'b1;
    end
    SCLK = 1'b1;
    MOSI = 1'b0;
    tick(8);
    n_vec++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL sshigh_busy got=%b exp=0", busy_seen); end
    n_vec++; if (rdy_cnt - r0 !== 0) begin n_err++; $display("FAIL sshigh_rdy got=%0d exp=0", rdy_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL sshigh_frm_err got=%0d exp=0", err_cnt - e0); end
    n_vec++; if (host_if.rx_data !== exp_rx) begin n_err++; $display("FAIL sshigh_rx got=%h exp=%h", host_if.rx_data, exp_rx); end
    for (int k = 0; k < 2; k++) begin
      tx = 16'($urandom);
      tx[15] = (k == 1);
      host_if.tx_data = tx;
      e0 = err_cnt;
      ss_low();
      n_vec++; if (MISO !== tx[15]) begin n_err++; $display("FAIL miso_first_bit[%0d] got=%b exp=%b", k, MISO, tx[15]); end
      n_vec++; if (host_if.busy !== 1'b1) begin n_err++; $display("FAIL ss_low_busy[%0d] got=%b exp=1", k, host_if.busy); end
      ss_high();
      tick(8);
      n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL empty_frame_err[%0d] got=%0d exp=1", k, err_cnt - e0); end
    end
  endtask

  task automatic test_exclusive();
    n_vec++; if (both_cnt !== 0) begin n_err++; $display("FAIL rdy_frm_err_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    rst  = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    host_if.tx_data = 16'h0000;
    test_reset();
    test_basic();
    test_abort();
    test_back_to_back();
    test_overlong();
    test_random();
    test_rst_midframe();
    test_ss_high();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
